// File: rtl/int_to_fp32_conv.sv
// Sequential int32 -> IEEE 754 binary32 converter, round-to-nearest-even.
// Normalises one bit per cycle. A start/ready/valid handshake frames each conversion.
module int_to_fp32_conv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] int_in,
    output logic        ready,
    output logic        valid,
    output logic [31:0] result,
    output logic        inexact
);

    localparam int unsigned W      = 32;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 23;
    localparam logic [EXP_W-1:0] EXP_INIT = 8'd158;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                sign;
    logic                zflag;
    logic [W-1:0]        mag;
    logic [EXP_W-1:0]    exp;

    logic                guard;
    logic                sticky;
    logic                round_up;
    logic [MANT_W:0]     mant_sum;
    logic [MANT_W-1:0]   mant_r;
    logic [EXP_W-1:0]    exp_r;
    logic                zero_hold;

    // Rounding: guard/sticky from the bits below the mantissa, carry into exponent
    always_comb begin
        guard     = mag[7];
        sticky    = |mag[6:0];
        round_up  = guard & (sticky | mag[8]);
        mant_sum  = {1'b0, mag[30:8]} + (MANT_W+1)'(round_up);
        mant_r    = mant_sum[MANT_W-1:0];
        exp_r     = exp + EXP_W'(mant_sum[MANT_W]);
        // A zero operand spends one extra ROUND cycle so its latency is 2, like the shortest nonzero path
        zero_hold = zflag && (exp != '0);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (int_in == '0) ? ROUND : NORM;
                end
            end
            NORM: begin
                if (mag[W-1]) begin
                    state_nxt = ROUND;
                end
            end
            ROUND: begin
                if (!zero_hold) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign    <= 1'b0;
            zflag   <= 1'b0;
            mag     <= '0;
            exp     <= '0;
            ready   <= 1'b1;
            valid   <= 1'b0;
            result  <= '0;
            inexact <= 1'b0;
        end else begin
            ready <= (state_nxt == IDLE);
            valid <= (state == ROUND) && !zero_hold;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign  <= int_in[W-1];
                        mag   <= int_in[W-1] ? W'(-int_in) : int_in;
                        exp   <= EXP_INIT;
                        zflag <= (int_in == '0);
                    end
                end
                NORM: begin
                    if (!mag[W-1]) begin
                        mag <= mag << 1;
                        exp <= exp - EXP_W'(1);
                    end
                end
                ROUND: begin
                    if (zero_hold) begin
                        exp <= '0;
                    end else if (zflag) begin
                        result  <= '0;
                        inexact <= 1'b0;
                    end else begin
                        result  <= {sign, exp_r, mant_r};
                        inexact <= guard | sticky;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_fp32_conv.sv
// Self-checking bench for int_to_fp32_conv: directed table, handshake corners, random sweep.
module tb_int_to_fp32_conv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] int_in;
    logic        ready;
    logic        valid;
    logic [31:0] result;
    logic        inexact;

    int n_chk  = 0;
    int n_fail = 0;

    int_to_fp32_conv dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .int_in  (int_in),
        .ready   (ready),
        .valid   (valid),
        .result  (result),
        .inexact (inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] din;
        logic [31:0] res;
        logic        inx;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Reference: exact magnitude, explicit RNE division by a power of two
    function automatic void ref_conv(input logic [31:0] x, output logic [31:0] r,
                                     output logic inx, output int lat);
        int     xi;
        longint m;
        longint q;
        longint rem;
        longint half;
        int     p;
        int     e;
        int     sh;
        xi = x;
        m  = (xi < 0) ? -longint'(xi) : longint'(xi);
        if (m == 0) begin
            r = 32'h0; inx = 1'b0; lat = 2;
            return;
        end
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        lat = (31 - p) + 2;
        e = 127 + p;
        rem = 0;
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            sh   = p - 23;
            q    = m >> sh;
            rem  = m - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (longint'(1) << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
        end
        r   = {x[31], 8'(e), 23'(q)};
        inx = (rem != 0);
    endfunction

    task automatic convert(input logic [31:0] x, output logic [31:0] r,
                           output logic inx, output int lat);
        @(negedge clk);
        start  = 1'b1;
        int_in = x;
        @(posedge clk);
        #1;
        start  = 1'b0;
        int_in = $urandom;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                lat = i;
                break;
            end
        end
        r   = result;
        inx = inexact;
    endtask

    vec_t        vecs[7];
    logic [31:0] r;
    logic        inx;
    int          lat;
    logic [31:0] er;
    logic        einx;
    int          elat;
    int          nv;
    logic [31:0] x;

    initial begin
        vecs[0] = '{32'h0000_0001, 32'h3F80_0000, 1'b0, 33};
        vecs[1] = '{32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 33};
        vecs[2] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 2};
        vecs[3] = '{32'h8000_0000, 32'hCF00_0000, 1'b0, 2};
        vecs[4] = '{32'h7FFF_FFFF, 32'h4F00_0000, 1'b1, 3};
        vecs[5] = '{32'd16777217,  32'h4B80_0000, 1'b1, 9};
        vecs[6] = '{32'd16777219,  32'h4B80_0002, 1'b1, 9};

        rst_n  = 1'b0;
        start  = 1'b0;
        int_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready",   32'(ready),   32'd1);
        chk("reset_valid",   32'(valid),   32'd0);
        chk("reset_result",  result,       32'h0);
        chk("reset_inexact", 32'(inexact), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 7; i++) begin
            convert(vecs[i].din, r, inx, lat);
            chk($sformatf("vec%0d_result", i),  r,         vecs[i].res);
            chk($sformatf("vec%0d_inexact", i), 32'(inx),  32'(vecs[i].inx));
            chk($sformatf("vec%0d_latency", i), 32'(lat),  32'(vecs[i].lat));
        end

        // Start while busy is ignored
        @(negedge clk);
        start = 1'b1; int_in = 32'd1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; int_in = 32'd5;
        @(negedge clk);
        start = 1'b0;
        nv = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                nv++;
                r = result;
            end
        end
        chk("busy_valid_count", 32'(nv), 32'd1);
        chk("busy_result",      r,       32'h3F80_0000);

        // Back-to-back: start held through the valid cycle
        @(negedge clk);
        start = 1'b1; int_in = 32'h8000_0000;
        @(posedge clk);
        #1 int_in = 32'd3;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                lat = i;
                break;
            end
        end
        chk("b2b_first_latency", 32'(lat),   32'd2);
        chk("b2b_first_result",  result,     32'hCF00_0000);
        chk("b2b_ready_in_valid", 32'(ready), 32'd1);
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                lat = i;
                break;
            end
        end
        chk("b2b_second_latency", 32'(lat), 32'd32);
        chk("b2b_second_result",  result,   32'h4040_0000);

        // Reset mid-conversion
        @(negedge clk);
        start = 1'b1; int_in = 32'd1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_ready",   32'(ready),   32'd1);
        chk("midrst_valid",   32'(valid),   32'd0);
        chk("midrst_result",  result,       32'h0);
        chk("midrst_inexact", 32'(inexact), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ready_after", 32'(ready), 32'd1);
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (valid) nv++;
        end
        chk("midrst_no_valid", 32'(nv), 32'd0);
        convert(32'd7, r, inx, lat);
        chk("midrst_new_result",  r,        32'h40E0_0000);
        chk("midrst_new_latency", 32'(lat), 32'd31);

        // Random sweep against the reference model
        for (int i = 0; i < 1500; i++) begin
            x = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) x = -x;
            ref_conv(x, er, einx, elat);
            convert(x, r, inx, lat);
            chk($sformatf("rnd_result(%h)", x),  r,        er);
            chk($sformatf("rnd_inexact(%h)", x), 32'(inx), 32'(einx));
            chk($sformatf("rnd_latency(%h)", x), 32'(lat), 32'(elat));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
